// File: rtl/y_dac_tx.sv
// Output end of the FIR path: sample pacer, 2-entry result buffer and 16-bit serial DAC transmitter.
// Optional build macro Y_OFFSET_BIN_EN: invert the word MSB on capture (two's complement -> offset binary).
module y_dac_tx #(
    parameter int DATA_W     = 12,
    parameter int SAMPLE_DIV = 2500,
    parameter int SCLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              leer_y,
    input  logic [DATA_W-1:0] y,
    output logic              cambiar,
    output logic              sync_n,
    output logic              sclk,
    output logic              sdo,
    output logic              busy,
    output logic              overrun
);

    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int HW = $clog2(SCLK_DIV + 1);
    localparam logic [SW-1:0] SMP_TC = SW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] HP_TC  = HW'(SCLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     smp_cnt;
    logic [HW-1:0]     hp_cnt;
    logic [4:0]        bit_cnt;
    logic [15:0]       sreg;
    logic              sclk_q;
    logic [DATA_W-1:0] mem [2];
    logic [DATA_W-1:0] conv;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              pop, push_ok, hp_tc;

    // Free-running sample pacer
    always_ff @(posedge clk) begin
        if (!rst)                 smp_cnt <= '0;
        else if (smp_cnt == SMP_TC) smp_cnt <= '0;
        else                      smp_cnt <= smp_cnt + 1'b1;
    end

    always_comb begin
        conv = y;
`ifdef Y_OFFSET_BIN_EN
        conv[DATA_W-1] = ~y[DATA_W-1];
`endif
    end

    // A pop in the same cycle frees a slot, so a full buffer still accepts the push
    assign pop     = (state == LOAD);
    assign push_ok = leer_y && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop};
            if (leer_y && !push_ok) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= conv;
    end

    assign hp_tc = (hp_cnt == HP_TC);

    // State register and serial datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            hp_cnt  <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            sclk_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    hp_cnt <= '0;
                    sclk_q <= 1'b1;
                end
                LOAD: begin
                    sreg    <= 16'(mem[rd_ptr]);
                    hp_cnt  <= '0;
                    bit_cnt <= '0;
                    sclk_q  <= 1'b1;
                end
                SHIFT: begin
                    if (hp_tc) begin
                        hp_cnt <= '0;
                        sclk_q <= ~sclk_q;
                        if (sclk_q)                 bit_cnt <= bit_cnt + 1'b1;
                        else if (bit_cnt != 5'd16)  sreg    <= {sreg[14:0], 1'b0};
                    end else begin
                        hp_cnt <= hp_cnt + 1'b1;
                    end
                end
                GAP: begin
                    hp_cnt <= hp_tc ? '0 : hp_cnt + 1'b1;
                    sclk_q <= 1'b1;
                end
                default: hp_cnt <= '0;
            endcase
        end
    end

    // GAP hands over straight to LOAD when a word waits, keeping the inter-frame gap at SCLK_DIV+1
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != 2'd0) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (hp_tc && !sclk_q && (bit_cnt == 5'd16)) state_nxt = GAP;
            GAP:     if (hp_tc) state_nxt = (count != 2'd0) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cambiar = (smp_cnt == SMP_TC);
        sync_n  = (state != SHIFT);
        busy    = (state == SHIFT) || (state == GAP);
        sdo     = (state == SHIFT) && sreg[15];
        sclk    = sclk_q;
    end

endmodule
